regfile_mp: RTL and testbench

- Parametrised multi-port register file: 2^M registers of N bits, two read ports, two masked write ports and a per-register busy scoreboard.
- Read data is registered. Reads return the post-write value of the same edge (write-before-read).
- The scoreboard lets multicycle producers reserve a destination register and release it on writeback. The issue logic stalls on the returned busy bits.

---
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: two registered read ports, two masked write ports
// and a per-register busy scoreboard. Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_mp #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] rd_addr_a,
  input  logic [M-1:0] rd_addr_b,
  output logic [N-1:0] rd_data_a,
  output logic [N-1:0] rd_data_b,
  output logic         rd_busy_a,
  output logic         rd_busy_b,
  input  logic         wr_en0,
  input  logic [M-1:0] wr_addr0,
  input  logic [N-1:0] wr_mask0,
  input  logic [N-1:0] wr_data0,
  input  logic         wr_rel0,
  input  logic         wr_en1,
  input  logic [M-1:0] wr_addr1,
  input  logic [N-1:0] wr_mask1,
  input  logic [N-1:0] wr_data1,
  input  logic         wr_rel1,
  input  logic         rsv_en,
  input  logic [M-1:0] rsv_addr,
  output logic         wr_conflict,
  output logic         rsv_err
);

  localparam int unsigned DEPTH = 2 ** M;

  logic [N-1:0]     regs_q [DEPTH];
  logic [N-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             conflict_d;
  logic             rsv_err_d;
  logic             rsv_take;
  logic             rsv_released;
  logic             conflict_addr_ok;

`ifdef REGFILE_ZERO_REG_EN
  assign rsv_take         = rsv_en && (rsv_addr != '0);
  assign conflict_addr_ok = (wr_addr0 != '0);
`else
  assign rsv_take         = rsv_en;
  assign conflict_addr_ok = 1'b1;
`endif

  // A reservation is not an error when the same edge releases that register.
  assign rsv_released = (wr_en0 && wr_rel0 && (wr_addr0 == rsv_addr)) ||
                        (wr_en1 && wr_rel1 && (wr_addr1 == rsv_addr));

  // Next state: port 0 then port 1 masked merge, release then reserve.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    conflict_d = 1'b0;
    rsv_err_d  = 1'b0;

    if (wr_en0) begin
      regs_d[wr_addr0] = (regs_d[wr_addr0] & ~wr_mask0) | (wr_data0 & wr_mask0);
    end
    if (wr_en1) begin
      regs_d[wr_addr1] = (regs_d[wr_addr1] & ~wr_mask1) | (wr_data1 & wr_mask1);
    end
`ifdef REGFILE_ZERO_REG_EN
    regs_d[0] = '0;
`endif

    conflict_d = wr_en0 && wr_en1 && (wr_addr0 == wr_addr1) &&
                 ((wr_mask0 & wr_mask1) != '0) && conflict_addr_ok;

    if (wr_en0 && wr_rel0) begin
      busy_d[wr_addr0] = 1'b0;
    end
    if (wr_en1 && wr_rel1) begin
      busy_d[wr_addr1] = 1'b0;
    end
    if (rsv_take) begin
      rsv_err_d        = busy_q[rsv_addr] && !rsv_released;
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      rd_data_a   <= '0;
      rd_data_b   <= '0;
      rd_busy_a   <= 1'b0;
      rd_busy_b   <= 1'b0;
      wr_conflict <= 1'b0;
      rsv_err     <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q      <= busy_d;
      // Reads see this edge's writes and scoreboard update.
      rd_data_a   <= regs_d[rd_addr_a];
      rd_data_b   <= regs_d[rd_addr_b];
      rd_busy_a   <= busy_d[rd_addr_a];
      rd_busy_b   <= busy_d[rd_addr_b];
      wr_conflict <= conflict_d;
      rsv_err     <= rsv_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed cases then random traffic against an array model.
module tb_regfile_mp;

  localparam int unsigned N     = 32;
  localparam int unsigned M     = 3;
  localparam int unsigned DEPTH = 8;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [M-1:0] rd_addr_a, rd_addr_b;
  logic [N-1:0] rd_data_a, rd_data_b;
  logic         rd_busy_a, rd_busy_b;
  logic         wr_en0, wr_rel0, wr_en1, wr_rel1;
  logic [M-1:0] wr_addr0, wr_addr1;
  logic [N-1:0] wr_mask0, wr_data0, wr_mask1, wr_data1;
  logic         rsv_en;
  logic [M-1:0] rsv_addr;
  logic         wr_conflict, rsv_err;

  regfile_mp #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_mask0(wr_mask0),
    .wr_data0(wr_data0), .wr_rel0(wr_rel0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_mask1(wr_mask1),
    .wr_data1(wr_data1), .wr_rel1(wr_rel1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_conflict(wr_conflict), .rsv_err(rsv_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] da;
    logic [N-1:0] db;
    logic         ba;
    logic         bb;
    logic         conf;
    logic         rerr;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] mreg  [DEPTH];
  bit           mbusy [DEPTH];

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected outputs.
  task automatic step(input logic [M-1:0] ra, input logic [M-1:0] rb,
                      input logic e0, input logic [M-1:0] a0, input logic [N-1:0] m0,
                      input logic [N-1:0] d0, input logic r0,
                      input logic e1, input logic [M-1:0] a1, input logic [N-1:0] m1,
                      input logic [N-1:0] d1, input logic r1,
                      input logic re, input logic [M-1:0] ra_rsv);
    exp_t e;
    bit   old_busy, released, rsv_ok;
    @(negedge clk);
    rd_addr_a = ra;  rd_addr_b = rb;
    wr_en0 = e0; wr_addr0 = a0; wr_mask0 = m0; wr_data0 = d0; wr_rel0 = r0;
    wr_en1 = e1; wr_addr1 = a1; wr_mask1 = m1; wr_data1 = d1; wr_rel1 = r1;
    rsv_en = re; rsv_addr = ra_rsv;

    old_busy = mbusy[ra_rsv];
    released = (e0 && r0 && a0 == ra_rsv) || (e1 && r1 && a1 == ra_rsv);
    rsv_ok   = re && !(ZERO && ra_rsv == 0);
    if (e0 && !(ZERO && a0 == 0)) mreg[a0] = (mreg[a0] & ~m0) | (d0 & m0);
    if (e1 && !(ZERO && a1 == 0)) mreg[a1] = (mreg[a1] & ~m1) | (d1 & m1);
    if (e0 && r0) mbusy[a0] = 1'b0;
    if (e1 && r1) mbusy[a1] = 1'b0;
    e.rerr = rsv_ok && old_busy && !released;
    if (rsv_ok) mbusy[ra_rsv] = 1'b1;
    e.conf = e0 && e1 && (a0 == a1) && ((m0 & m1) != 0) && !(ZERO && a0 == 0);
    e.da = mreg[ra];
    e.db = mreg[rb];
    e.ba = mbusy[ra];
    e.bb = mbusy[rb];
    q.push_back(e);
  endtask

  task automatic idle(input logic [M-1:0] ra, input logic [M-1:0] rb);
    step(ra, rb, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Wait until the outputs of the last step are stable.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_data_a"}, rd_data_a, '0);
    chk({tag, "_rd_data_b"}, rd_data_b, '0);
    chk({tag, "_rd_busy_a"}, N'(rd_busy_a), '0);
    chk({tag, "_rd_busy_b"}, N'(rd_busy_b), '0);
    chk({tag, "_wr_conflict"}, N'(wr_conflict), '0);
    chk({tag, "_rsv_err"}, N'(rsv_err), '0);
  endtask

  // Monitor: outputs are presented every cycle, compare one queued entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_rd_data_a", rd_data_a, e.da);
        chk("sb_rd_data_b", rd_data_b, e.db);
        chk("sb_rd_busy_a", N'(rd_busy_a), N'(e.ba));
        chk("sb_rd_busy_b", N'(rd_busy_b), N'(e.bb));
        chk("sb_wr_conflict", N'(wr_conflict), N'(e.conf));
        chk("sb_rsv_err", N'(rsv_err), N'(e.rerr));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] m0, m1;
    rst = 1'b1;
    rd_addr_a = '0; rd_addr_b = '0;
    wr_en0 = 0; wr_addr0 = '0; wr_mask0 = '0; wr_data0 = '0; wr_rel0 = 0;
    wr_en1 = 0; wr_addr1 = '0; wr_mask1 = '0; wr_data1 = '0; wr_rel1 = 0;
    rsv_en = 0; rsv_addr = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk_all_zero("por");
    rst = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) idle(M'(i), M'(DEPTH - 1 - i));

    step(3, 3, 1, 3, 32'hFFFFFFFF, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("wr_full_fwd", rd_data_a, 32'hDEADBEEF);
    step(3, 3, 1, 3, 32'h0000FFFF, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("wr_masked", rd_data_a, 32'hDEAD5678);

    step(5, 5, 1, 5, 32'hFFFF0000, 32'hAAAAAAAA, 0, 1, 5, 32'h0000FFFF, 32'h55555555, 0, 0, 0);
    settle();
    chk("dual_disjoint", rd_data_b, 32'hAAAA5555);
    chk("dual_disjoint_conf", N'(wr_conflict), '0);
    step(5, 5, 1, 5, 32'hFFFFFFFF, 32'hAAAAAAAA, 0, 1, 5, 32'hFFFFFFFF, 32'h55555555, 0, 0, 0);
    settle();
    chk("dual_overlap", rd_data_a, 32'h55555555);
    chk("dual_overlap_conf", N'(wr_conflict), 1);
    idle(5, 5);
    settle();
    chk("conf_pulse_end", N'(wr_conflict), '0);

    step(2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    settle();
    chk("rsv_busy", N'(rd_busy_a), 1);
    step(2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    settle();
    chk("rsv_again_err", N'(rsv_err), 1);
    chk("rsv_again_busy", N'(rd_busy_b), 1);
    step(2, 2, 0, 0, 0, 0, 0, 1, 2, 32'h0, 32'h0, 1, 0, 0);
    settle();
    chk("rel_busy", N'(rd_busy_a), '0);
    chk("rel_err_clear", N'(rsv_err), '0);
    step(2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    step(2, 2, 0, 0, 0, 0, 0, 1, 2, 32'hFF, 32'h77, 1, 1, 2);
    settle();
    chk("rel_rsv_busy", N'(rd_busy_a), 1);
    chk("rel_rsv_noerr", N'(rsv_err), '0);

    step(0, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("zero_data", rd_data_a, ZERO ? 32'h0 : 32'hFFFFFFFF);
    chk("zero_busy", N'(rd_busy_b), ZERO ? 32'h0 : 32'h1);
    chk("zero_err", N'(rsv_err), '0);

    step(3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    idle(3, 2);
    idle(0, 5);

    repeat (400) begin
      m0 = ($urandom_range(0, 3) == 0) ? 32'h0 : (($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF : $urandom);
      m1 = ($urandom_range(0, 3) == 0) ? 32'h0 : (($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF : $urandom);
      step(M'($urandom), M'($urandom),
           1'($urandom), M'($urandom_range(0, 3)), m0, $urandom, 1'($urandom),
           1'($urandom), M'($urandom_range(0, 3)), m1, $urandom, 1'($urandom),
           1'($urandom), M'($urandom_range(0, 3)));
    end
    idle(0, 1);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
